// File: rtl/obi_mem_responder.sv
// obi_mem_responder: req/gnt/rvalid memory endpoint with fixed-latency in-order responses
// Optional random grant stalls via OBI_RESP_RANDOM_STALL_EN.
module obi_mem_responder #(
    parameter int unsigned MEM_WORDS       = 4096,
    parameter logic [31:0] MEM_START       = 32'h0000_0000,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int unsigned IW = $clog2(MEM_WORDS);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic        v;
        logic        e;
        logic [31:0] d;
    } rsp_t;

    logic [31:0]          mem [MEM_WORDS];
    logic [31:0]          off;
    logic [IW-1:0]        idx;
    logic                 in_win;
    logic                 acc;
    logic                 stall;
    logic [CW-1:0]        cnt_q, cnt_d;
    rsp_t [LATENCY-1:0]   pipe_q, pipe_d;

    assign off    = addr_i - MEM_START;
    assign in_win = (off >> 2) < MEM_WORDS;
    assign idx    = off[IW+1:2];
    assign gnt_o  = (cnt_q < CW'(MAX_OUTSTANDING)) & ~stall;
    assign acc    = req_i & gnt_o;

    always_comb begin
        pipe_d      = '0;
        pipe_d[0].v = acc;
        pipe_d[0].e = acc & ~in_win;
        pipe_d[0].d = (acc & ~we_i & in_win) ? mem[idx] : '0;
        for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
        cnt_d       = cnt_q + CW'(acc) - CW'(rvalid_o);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_q <= '0;
            cnt_q  <= '0;
        end else begin
            pipe_q <= pipe_d;
            cnt_q  <= cnt_d;
        end
    end

    // RAM is deliberately outside the reset domain so accepted writes survive a reset
    always_ff @(posedge clk_i) begin
        if (acc & we_i & in_win)
            for (int b = 0; b < 4; b++)
                if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
    end

    assign rvalid_o = pipe_q[LATENCY-1].v;
    assign rdata_o  = pipe_q[LATENCY-1].d;
    assign err_o    = pipe_q[LATENCY-1].e;

`ifdef OBI_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign stall  = lfsr_q[1:0] == 2'b00;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign stall = 1'b0;
`endif
endmodule
